// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory handshakes of mem_port_arbiter.
// master is the arbiter's view; slave is the surrounding core/memory view.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ready;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ready;

   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;

   logic          err;
   logic          stall;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      output if_rdata, if_ready, d_rdata, d_ready,
      output m_req, m_we, m_addr, m_wdata, err, stall
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      input  if_rdata, if_ready, d_rdata, d_ready,
      input  m_req, m_we, m_addr, m_wdata, err, stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Optional one-entry fetch buffer enabled by defining ARB_IBUF_EN.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.master  bus
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEM,
      S_RESP
   } state_e;

   typedef enum logic {
      G_IF,
      G_D
   } grant_e;

   state_e        state_q, state_d;
   grant_e        owner_q, owner_d;
   grant_e        last_q, last_d;
   grant_e        gnt;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          m_req_q, m_req_d;
   logic          m_we_q, m_we_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [DW-1:0] m_wdata_q, m_wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;

`ifdef ARB_IBUF_EN
   logic          ibuf_valid_q, ibuf_valid_d;
   logic [AW-3:0] ibuf_tag_q, ibuf_tag_d;
   logic [DW-1:0] ibuf_data_q, ibuf_data_d;
   logic          ibuf_hit;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         owner_q    <= G_IF;
         last_q     <= G_IF;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
`ifdef ARB_IBUF_EN
         ibuf_valid_q <= 1'b0;
         ibuf_tag_q   <= '0;
         ibuf_data_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         m_req_q    <= m_req_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
`ifdef ARB_IBUF_EN
         ibuf_valid_q <= ibuf_valid_d;
         ibuf_tag_q   <= ibuf_tag_d;
         ibuf_data_q  <= ibuf_data_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      m_req_d    = m_req_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
`ifdef ARB_IBUF_EN
      ibuf_valid_d = ibuf_valid_q;
      ibuf_tag_d   = ibuf_tag_q;
      ibuf_data_d  = ibuf_data_q;
      ibuf_hit     = ibuf_valid_q && (bus.if_addr[AW-1:2] == ibuf_tag_q);
`endif

      // Under contention the requester opposite the previous grant wins.
      gnt = G_IF;
      if (bus.d_req && (!bus.if_req || last_q == G_IF)) begin
         gnt = G_D;
      end

      unique case (state_q)
         S_IDLE: begin
            err_d = 1'b0;
            if (bus.if_req || bus.d_req) begin
               owner_d = gnt;
               last_d  = gnt;
               cnt_d   = '0;
               if (gnt == G_D) begin
                  m_req_d   = 1'b1;
                  m_we_d    = bus.d_we;
                  m_addr_d  = bus.d_addr;
                  m_wdata_d = bus.d_wdata;
                  state_d   = S_MEM;
`ifdef ARB_IBUF_EN
                  if (bus.d_we && (bus.d_addr[AW-1:2] == ibuf_tag_q)) begin
                     ibuf_valid_d = 1'b0;
                  end
`endif
               end else begin
`ifdef ARB_IBUF_EN
                  if (ibuf_hit) begin
                     if_rdata_d = ibuf_data_q;
                     state_d    = S_RESP;
                  end else begin
                     m_req_d   = 1'b1;
                     m_we_d    = 1'b0;
                     m_addr_d  = bus.if_addr;
                     m_wdata_d = '0;
                     state_d   = S_MEM;
                  end
`else
                  m_req_d   = 1'b1;
                  m_we_d    = 1'b0;
                  m_addr_d  = bus.if_addr;
                  m_wdata_d = '0;
                  state_d   = S_MEM;
`endif
               end
            end
         end

         S_MEM: begin
            cnt_d = cnt_q + 1'b1;
            // An ack in the final permitted cycle still completes normally.
            if (bus.m_ack) begin
               m_req_d = 1'b0;
               state_d = S_RESP;
               if (owner_q == G_IF) begin
                  if_rdata_d = bus.m_rdata;
`ifdef ARB_IBUF_EN
                  ibuf_valid_d = 1'b1;
                  ibuf_tag_d   = m_addr_q[AW-1:2];
                  ibuf_data_d  = bus.m_rdata;
`endif
               end else if (!m_we_q) begin
                  d_rdata_d = bus.m_rdata;
               end
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               m_req_d = 1'b0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.if_ready = (state_q == S_RESP) && (owner_q == G_IF);
   assign bus.d_ready  = (state_q == S_RESP) && (owner_q == G_D);
   assign bus.err      = err_q;
   assign bus.m_req    = m_req_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.stall    = (bus.if_req & ~bus.if_ready) | (bus.d_req & ~bus.d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised episode bench for mem_port_arbiter with a transaction-timeline model.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 6;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Memory responder: acks after a queued latency, optionally sprinkles stray acks while idle.
   int unsigned lat_q[$];
   logic [31:0] rd_q[$];
   int unsigned mcnt = 0;
   int unsigned cur_lat = 0;
   logic [31:0] cur_rd = '0;
   bit          force_ack = 1'b0;
   bit          spur_en = 1'b0;

   initial begin
      bus.m_ack   = 1'b0;
      bus.m_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.m_req === 1'b1) begin
            if (mcnt == 0) begin
               cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
               cur_rd  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
            end
            bus.m_ack   = (mcnt == cur_lat);
            bus.m_rdata = (mcnt == cur_lat) ? cur_rd : $urandom;
            mcnt++;
         end else begin
            mcnt        = 0;
            bus.m_ack   = force_ack | (spur_en & ($urandom_range(0, 3) == 0));
            bus.m_rdata = $urandom;
         end
      end
   end

   // Expected per-cycle timeline of the current episode.
   logic        e_mreq[64], e_mwe[64], e_ifr[64], e_dr[64], e_err[64], e_stall[64];
   logic [31:0] e_maddr[64], e_mwdata[64], e_ifrd[64], e_drd[64];
   int unsigned cyc_i = 0;
   bit          chk_en = 1'b0;

   bit          m_last_d = 1'b0;
   logic [31:0] m_ifrd = '0;
   logic [31:0] m_drd = '0;

   int unsigned obs_mreq_n, obs_stall_n, obs_rise_n, obs_ifr_cyc, obs_dr_cyc;
   logic [31:0] obs_ifr_data, obs_dr_data, obs_r1_addr, obs_r2_addr, obs_r1_wdata;
   logic        obs_r1_we, obs_r2_we, obs_dr_err, prev_mreq = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_req", bus.m_req, e_mreq[cyc_i]);
         if (e_mreq[cyc_i]) begin
            chk("m_addr", bus.m_addr, e_maddr[cyc_i]);
            chk("m_we", bus.m_we, e_mwe[cyc_i]);
            if (e_mwe[cyc_i]) chk("m_wdata", bus.m_wdata, e_mwdata[cyc_i]);
         end
         chk("if_ready", bus.if_ready, e_ifr[cyc_i]);
         chk("d_ready", bus.d_ready, e_dr[cyc_i]);
         chk("err", bus.err, e_err[cyc_i]);
         chk("stall", bus.stall, e_stall[cyc_i]);
         chk("if_rdata", bus.if_rdata, e_ifrd[cyc_i]);
         chk("d_rdata", bus.d_rdata, e_drd[cyc_i]);

         obs_mreq_n  += bus.m_req;
         obs_stall_n += bus.stall;
         if (bus.m_req && !prev_mreq) begin
            obs_rise_n++;
            if (obs_rise_n == 1) begin
               obs_r1_addr  = bus.m_addr;
               obs_r1_we    = bus.m_we;
               obs_r1_wdata = bus.m_wdata;
            end else if (obs_rise_n == 2) begin
               obs_r2_addr = bus.m_addr;
               obs_r2_we   = bus.m_we;
            end
         end
         if (bus.if_ready) begin
            obs_ifr_cyc  = cyc_i;
            obs_ifr_data = bus.if_rdata;
         end
         if (bus.d_ready) begin
            obs_dr_cyc  = cyc_i;
            obs_dr_data = bus.d_rdata;
            obs_dr_err  = bus.err;
         end
      end
      prev_mreq = bus.m_req;
   end

   // lat0/rd0 belong to the first granted transaction, lat1/rd1 to the second.
   task automatic run_episode(input bit wi, input bit wd, input logic [31:0] ia,
                              input bit dwe, input logic [31:0] da, input logic [31:0] dwd,
                              input int unsigned lat0, input int unsigned lat1,
                              input logic [31:0] rd0, input logic [31:0] rd1,
                              input int unsigned gap);
      bit          own[2];
      int unsigned lat[2];
      logic [31:0] rdv[2];
      int unsigned n, t, mend, rdy, rdy_if, rdy_d, len;
      bit          d_first, ab;
      n = 0;
      d_first = wd && (!wi || !m_last_d);
      if (wd && d_first) begin own[n] = 1'b1; n++; end
      if (wi) begin own[n] = 1'b0; n++; end
      if (wd && !d_first) begin own[n] = 1'b1; n++; end
      lat[0] = lat0; lat[1] = lat1;
      rdv[0] = rd0;  rdv[1] = rd1;
      for (int c = 0; c < 64; c++) begin
         e_mreq[c] = 0; e_mwe[c] = 0; e_ifr[c] = 0; e_dr[c] = 0; e_err[c] = 0; e_stall[c] = 0;
         e_maddr[c] = '0; e_mwdata[c] = '0; e_ifrd[c] = m_ifrd; e_drd[c] = m_drd;
      end
      t = 0; rdy_if = 0; rdy_d = 0;
      for (int unsigned k = 0; k < n; k++) begin
         lat_q.push_back(lat[k]);
         rd_q.push_back(rdv[k]);
         ab   = (lat[k] >= TO);
         mend = ab ? t + TO : t + 1 + lat[k];
         for (int unsigned c = t + 1; c <= mend; c++) begin
            e_mreq[c]   = 1'b1;
            e_maddr[c]  = own[k] ? da : ia;
            e_mwe[c]    = own[k] ? dwe : 1'b0;
            e_mwdata[c] = dwd;
         end
         rdy = mend + 1;
         e_err[rdy] = ab;
         if (own[k]) begin
            e_dr[rdy] = 1'b1;
            rdy_d = rdy;
            if (!ab && !dwe) begin
               m_drd = rdv[k];
               for (int unsigned c = rdy; c < 64; c++) e_drd[c] = m_drd;
            end
         end else begin
            e_ifr[rdy] = 1'b1;
            rdy_if = rdy;
            if (!ab) begin
               m_ifrd = rdv[k];
               for (int unsigned c = rdy; c < 64; c++) e_ifrd[c] = m_ifrd;
            end
         end
         m_last_d = own[k];
         t = rdy + 1;
      end
      len = t + gap;
      for (int unsigned c = 0; c < len; c++) begin
         e_stall[c] = (wi && c < rdy_if) || (wd && c < rdy_d);
      end
      obs_mreq_n = 0; obs_stall_n = 0; obs_rise_n = 0; obs_ifr_cyc = 99; obs_dr_cyc = 99;
      obs_ifr_data = 'x; obs_dr_data = 'x; obs_dr_err = 1'b0;
      for (int unsigned c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         bus.if_req  = wi && (c <= rdy_if);
         bus.d_req   = wd && (c <= rdy_d);
         bus.if_addr = ia;
         bus.d_we    = dwe;
         bus.d_addr  = da;
         bus.d_wdata = dwd;
         cyc_i  = c;
         chk_en = 1'b1;
      end
      @(negedge clk);
      #1;
      chk_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = '0; bus.d_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst m_req", bus.m_req, 1'b0);
      chk("rst m_we", bus.m_we, 1'b0);
      chk("rst m_addr", bus.m_addr, 32'h0);
      chk("rst m_wdata", bus.m_wdata, 32'h0);
      chk("rst if_ready", bus.if_ready, 1'b0);
      chk("rst d_ready", bus.d_ready, 1'b0);
      chk("rst err", bus.err, 1'b0);
      chk("rst if_rdata", bus.if_rdata, 32'h0);
      chk("rst d_rdata", bus.d_rdata, 32'h0);
      reset = 1'b0;

      // Contention from reset: data wins first, fetch follows without overlap.
      run_episode(1, 1, 32'h0000_0080, 1, 32'h0000_0050, 32'hDEAD_BEEF, 0, 0,
                  32'h1111_1111, 32'h2222_2222, 0);
      chk("arb rises", obs_rise_n, 2);
      chk("arb first we", obs_r1_we, 1'b1);
      chk("arb first addr", obs_r1_addr, 32'h50);
      chk("arb first wdata", obs_r1_wdata, 32'hDEAD_BEEF);
      chk("arb second addr", obs_r2_addr, 32'h80);
      chk("arb second we", obs_r2_we, 1'b0);
      chk("arb mreq cycles", obs_mreq_n, 2);
      chk("arb d_ready cyc", obs_dr_cyc, 2);
      chk("arb if_ready cyc", obs_ifr_cyc, 5);

      run_episode(1, 0, 32'h0000_0040, 0, 32'h0, 32'h0, 0, 0, 32'h8C02_0004, 32'h0, 1);
      chk("if1 mreq cycles", obs_mreq_n, 1);
      chk("if1 addr", obs_r1_addr, 32'h40);
      chk("if1 we", obs_r1_we, 1'b0);
      chk("if1 ready cyc", obs_ifr_cyc, 2);
      chk("if1 rdata", obs_ifr_data, 32'h8C02_0004);
      chk("if1 stall cycles", obs_stall_n, 2);

      run_episode(0, 1, 32'h0, 0, 32'h0000_0300, 32'h0, 5, 0, 32'hA5A5_0001, 32'h0, 0);
      chk("dwait mreq cycles", obs_mreq_n, 6);
      chk("dwait ready cyc", obs_dr_cyc, 7);
      chk("dwait rdata", obs_dr_data, 32'hA5A5_0001);
      chk("dwait err", obs_dr_err, 1'b0);

      run_episode(0, 1, 32'h0, 0, 32'h0000_0304, 32'h0, 9, 0, 32'h5555_AAAA, 32'h0, 0);
      chk("tmo mreq cycles", obs_mreq_n, 6);
      chk("tmo ready cyc", obs_dr_cyc, 7);
      chk("tmo err", obs_dr_err, 1'b1);
      chk("tmo rdata kept", obs_dr_data, 32'hA5A5_0001);

      // Reset during MEM, then a stray ack right after it.
      lat_q.push_back(20);
      rd_q.push_back(32'hFFFF_0000);
      @(posedge clk); #1;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; bus.d_req = 0; force_ack = 1'b1;
      @(negedge clk);
      chk("rstmid m_req", bus.m_req, 1'b0);
      chk("rstmid d_ready", bus.d_ready, 1'b0);
      chk("rstmid err", bus.err, 1'b0);
      @(posedge clk); #1;
      force_ack = 1'b0;
      @(negedge clk);
      chk("rstmid late m_req", bus.m_req, 1'b0);
      chk("rstmid late d_ready", bus.d_ready, 1'b0);
      chk("rstmid d_rdata", bus.d_rdata, 32'h0);
      m_last_d = 1'b0; m_ifrd = '0; m_drd = '0;
      run_episode(1, 0, 32'h0000_0044, 0, 32'h0, 32'h0, 1, 0, 32'h0BAD_F00D, 32'h0, 0);
      chk("after rst ready cyc", obs_ifr_cyc, 3);
      chk("after rst rdata", obs_ifr_data, 32'h0BAD_F00D);

      spur_en = 1'b1;
      for (int i = 0; i < 150; i++) begin
         int unsigned r;
         r = $urandom_range(1, 3);
         run_episode(r[0], r[1], $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                     $urandom & 32'hFFFF_FFFC, $urandom,
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom, $urandom,
                     $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
